// File: rtl/note_tone_pkg.sv
// Shared widths, the note-increment record and the elaboration-time constant functions
// used to build the note-to-increment table and the sine ROM of the tone core.
package note_tone_pkg;

    localparam int NOTE_W      = 5;
    localparam int JUMP_W      = 7;
    localparam int FRAC_W      = 29;
    localparam int PHASE_W     = 9;
    localparam int VALUE_W     = 9;
    localparam int SINE_MID    = 256;
    localparam int SINE_AMP    = 255;

    localparam int NOTE_COUNT  = 1 << NOTE_W;
    localparam int PHASE_COUNT = 1 << PHASE_W;
    localparam int QUARTER_LEN = PHASE_COUNT / 4 + 1;
    localparam int JUMP_MAX    = (1 << JUMP_W) - 1;

    localparam real PI         = 3.14159265358979323846;
    localparam real A4_FREQ_HZ = 440.0;

    typedef struct packed {
        logic [JUMP_W-1:0] jump;
        logic [FRAC_W-1:0] rem;
    } note_inc_t;

    // 2^(k/12) without library math: split into whole octaves (exact powers of two) and a
    // semitone offset s in 0..11, whose ratio is the Newton root of y^12 = 2^s.
    function automatic real semitone_ratio(input int k);
        int  oct;
        int  s;
        real target;
        real y;
        real p;
        real scale;
        oct = (k >= 0) ? (k / 12) : -((11 - k) / 12);
        s   = k - 12 * oct;
        target = 1.0;
        for (int i = 0; i < s; i++) begin
            target = target * 2.0;
        end
        y = 1.0 + real'(s) / 12.0;
        for (int it = 0; it < 40; it++) begin
            p = 1.0;
            for (int j = 0; j < 11; j++) begin
                p = p * y;
            end
            y = y - (p * y - target) / (12.0 * p);
        end
        scale = 1.0;
        if (oct >= 0) begin
            for (int i = 0; i < oct; i++) begin
                scale = scale * 2.0;
            end
        end else begin
            for (int i = 0; i < -oct; i++) begin
                scale = scale * 0.5;
            end
        end
        return y * scale;
    endfunction

    function automatic real note_freq(input int n, input int a4);
        real f;
        if (n == 0) begin
            f = 0.0;
        end else begin
            f = A4_FREQ_HZ * semitone_ratio(n - a4);
        end
        return f;
    endfunction

    function automatic real note_inc(input int n, input int a4, input int clk_hz);
        return note_freq(n, a4) * real'(PHASE_COUNT) / real'(clk_hz);
    endfunction

    // Fraction rounded half-up in units of 1/frac_den; a value that rounds up to frac_den is
    // returned as-is here so note_jump and note_rem can each fold the carry their own way.
    function automatic int note_frac_raw(input int n, input int a4, input int clk_hz,
                                         input int frac_den);
        real inc;
        int  j;
        inc = note_inc(n, a4, clk_hz);
        j   = $rtoi(inc);
        return $rtoi((inc - real'(j)) * real'(frac_den) + 0.5);
    endfunction

    function automatic int note_jump(input int n, input int a4, input int clk_hz,
                                     input int frac_den);
        int j;
        if (n == 0) begin
            j = 0;
        end else begin
            j = $rtoi(note_inc(n, a4, clk_hz));
            if (note_frac_raw(n, a4, clk_hz, frac_den) >= frac_den) begin
                j = j + 1;
            end
            if (j > JUMP_MAX) begin
                j = JUMP_MAX;
            end
        end
        return j;
    endfunction

    function automatic int note_rem(input int n, input int a4, input int clk_hz,
                                    input int frac_den);
        int r;
        if (n == 0) begin
            r = 0;
        end else begin
            r = note_frac_raw(n, a4, clk_hz, frac_den);
            if (r >= frac_den) begin
                r = 0;
            end
        end
        return r;
    endfunction

    // Taylor series, only ever evaluated on the first quadrant [0, pi/2].
    function automatic real sin_quadrant(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k < 16; k++) begin
            term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Every sample is folded onto the quarter wave before rounding, so the full and the
    // quarter-wave ROM builds are bit-identical by construction.
    function automatic int sine_sample(input int p);
        int  quadrant;
        int  offset;
        int  idx;
        int  mag;
        real x;
        quadrant = (p / (PHASE_COUNT / 4)) % 4;
        offset   = p % (PHASE_COUNT / 4);
        idx      = (quadrant % 2 == 1) ? (PHASE_COUNT / 4 - offset) : offset;
        x        = (PI / 2.0) * real'(idx) / real'(PHASE_COUNT / 4);
        mag      = $rtoi(real'(SINE_AMP) * sin_quadrant(x) + 0.5);
        return (quadrant >= 2) ? (SINE_MID - mag) : (SINE_MID + mag);
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered 512-entry sine ROM with one cycle of read latency and an async reset to midscale.
// Build option QUARTER_WAVE_ROM_EN stores only phases 0..128 and rebuilds the rest by symmetry.
module sine_lut
    import note_tone_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase,
    output logic [VALUE_W-1:0] value
);

    logic [VALUE_W-1:0] w_sample;
    logic [VALUE_W-1:0] r_value;

`ifdef QUARTER_WAVE_ROM_EN
    localparam logic [VALUE_W:0] FULL_SCALE = (VALUE_W + 1)'(2 * SINE_MID);

    logic [VALUE_W-1:0] w_quarterRom [QUARTER_LEN];
    logic [1:0]         w_quadrant;
    logic [PHASE_W-3:0] w_offset;
    logic [PHASE_W-2:0] w_romAddr;
    logic [VALUE_W-1:0] w_romValue;

    for (genvar i = 0; i < QUARTER_LEN; i++) begin : g_quarter
        localparam logic [VALUE_W-1:0] SAMPLE = VALUE_W'(sine_sample(i));
        assign w_quarterRom[i] = SAMPLE;
    end

    assign w_quadrant = phase[PHASE_W-1:PHASE_W-2];
    assign w_offset   = phase[PHASE_W-3:0];

    // Odd quadrants run the quarter wave backwards, so entry 128 (the peak) is needed.
    assign w_romAddr  = w_quadrant[0] ? ((PHASE_W - 1)'(QUARTER_LEN - 1) - {1'b0, w_offset})
                                      : {1'b0, w_offset};
    assign w_romValue = w_quarterRom[w_romAddr];

    assign w_sample   = w_quadrant[1] ? VALUE_W'(FULL_SCALE - {1'b0, w_romValue})
                                      : w_romValue;
`else
    logic [VALUE_W-1:0] w_fullRom [PHASE_COUNT];

    for (genvar i = 0; i < PHASE_COUNT; i++) begin : g_full
        localparam logic [VALUE_W-1:0] SAMPLE = VALUE_W'(sine_sample(i));
        assign w_fullRom[i] = SAMPLE;
    end

    assign w_sample = w_fullRom[phase];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= VALUE_W'(SINE_MID);
        end else begin
            r_value <= w_sample;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/note_tone_core.sv
// Tone core: combinational note-to-phase-increment table plus the registered sine lookup.
// Define QUARTER_WAVE_ROM_EN to build the sine lookup from a quarter-wave ROM.
module note_tone_core
    import note_tone_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FRAC_DEN = 100_000_000,
    parameter int A4_NOTE  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NOTE_W-1:0]  note,
    output logic [JUMP_W-1:0]  jump,
    output logic [FRAC_W-1:0]  remainder,
    input  logic [PHASE_W-1:0] phase,
    output logic [VALUE_W-1:0] value
);

    note_inc_t w_incTable [NOTE_COUNT];
    note_inc_t w_incSel;

    // Each entry is a localparam so the real arithmetic is resolved entirely at elaboration.
    for (genvar n = 0; n < NOTE_COUNT; n++) begin : g_note
        localparam note_inc_t INC = '{
            jump: JUMP_W'(note_jump(n, A4_NOTE, CLK_HZ, FRAC_DEN)),
            rem:  FRAC_W'(note_rem(n, A4_NOTE, CLK_HZ, FRAC_DEN))
        };
        assign w_incTable[n] = INC;
    end

    assign w_incSel  = w_incTable[note];
    assign jump      = w_incSel.jump;
    assign remainder = w_incSel.rem;

    sine_lut u_sine_lut (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .value (value)
    );

endmodule

// File: tb/tb_note_tone_core.sv
// Scoreboard bench for note_tone_core: stimulus queues expected responses, one monitor
// process pops and compares them against the note table and the sine output.
module tb_note_tone_core;

    localparam int  CLK_HZ   = 100_000_000;
    localparam int  FRAC_DEN = 100_000_000;
    localparam int  A4_NOTE  = 10;
    localparam real TB_PI    = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] note = '0;
    logic [8:0] phase = '0;
    logic [6:0] jump;
    logic [28:0] remainder;
    logic [8:0] value;

    note_tone_core #(
        .CLK_HZ   (CLK_HZ),
        .FRAC_DEN (FRAC_DEN),
        .A4_NOTE  (A4_NOTE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note      (note),
        .jump      (jump),
        .remainder (remainder),
        .phase     (phase),
        .value     (value)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int j;
        int r;
        bit exact;
    } noteExp_t;

    typedef struct {
        int ph;
        int val;
    } sineExp_t;

    noteExp_t noteQ[$];
    sineExp_t sineQ[$];
    int       directQ[$];

    bit noteReq = 1'b0;
    bit sineReq = 1'b0;
    bit sinePending = 1'b0;
    bit directReq = 1'b0;
    bit finalReq = 1'b0;

    int assertCount = 0;
    int failCount = 0;

    noteExp_t monNote;
    sineExp_t monSine;
    int       monDirect;
    int       prevNote = -10;
    int       prevRem = 0;
    int       prevPhase = -10;
    int       prevValue = 0;
    int       stepDiff;
    longint   carries;

    // Reference model: the textbook formulas evaluated with library real math.
    function automatic real modelInc(input int n);
        return 440.0 * $pow(2.0, real'(n - A4_NOTE) / 12.0) * 512.0 / real'(CLK_HZ);
    endfunction

    function automatic int modelJump(input int n);
        real inc;
        real fr;
        int  j;
        if (n == 0) return 0;
        inc = modelInc(n);
        j   = $rtoi($floor(inc));
        fr  = $floor((inc - real'(j)) * real'(FRAC_DEN) + 0.5);
        if (fr >= real'(FRAC_DEN)) j = j + 1;
        if (j > 127) j = 127;
        return j;
    endfunction

    function automatic int modelRem(input int n);
        real inc;
        real fr;
        if (n == 0) return 0;
        inc = modelInc(n);
        fr  = $floor((inc - $floor(inc)) * real'(FRAC_DEN) + 0.5);
        if (fr >= real'(FRAC_DEN)) fr = 0.0;
        return $rtoi(fr);
    endfunction

    function automatic int modelSine(input int p);
        real x;
        real r;
        x = 255.0 * $sin(2.0 * TB_PI * real'(p) / 512.0);
        r = (x >= 0.0) ? $floor(x + 0.5) : -$floor(-x + 0.5);
        return 256 + $rtoi(r);
    endfunction

    task automatic checkOutput(input string name, input bit ok, input longint got,
                               input longint want);
        assertCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // wantJ/wantR < 0 and wantV < 0 select the reference model instead of a fixed constant.
    task automatic applyStimulus(input int n, input int p, input bit doNote, input bit doSine,
                                 input int wantJ, input int wantR, input int wantV);
        noteExp_t ne;
        sineExp_t se;
        note  = 5'(n);
        phase = 9'(p);
        if (doNote) begin
            ne.n     = n;
            ne.exact = (wantR >= 0);
            ne.j     = (wantJ >= 0) ? wantJ : modelJump(n);
            ne.r     = (wantR >= 0) ? wantR : modelRem(n);
            noteQ.push_back(ne);
        end
        if (doSine) begin
            se.ph  = p;
            se.val = (wantV >= 0) ? wantV : modelSine(p);
            sineQ.push_back(se);
        end
        noteReq = doNote;
        sineReq = doSine;
        @(posedge clk);
        #1;
    endtask

    task automatic expectDirect(input int want);
        directQ.push_back(want);
        directReq = 1'b1;
        @(negedge clk);
        #1;
        directReq = 1'b0;
    endtask

    always @(posedge clk) begin
        sinePending <= sineReq;
    end

    always @(negedge clk) begin
        if (noteReq) begin
            if (noteQ.size() == 0) begin
                checkOutput("noteQueueEmpty", 1'b0, 0, 1);
            end else begin
                monNote = noteQ.pop_front();
                checkOutput("jump", int'(jump) == monNote.j, jump, monNote.j);
                if (monNote.exact)
                    checkOutput("remExact", int'(remainder) == monNote.r, remainder, monNote.r);
                else
                    checkOutput("remModel", (int'(remainder) >= monNote.r - 1) &&
                                (int'(remainder) <= monNote.r + 1), remainder, monNote.r);
                checkOutput("remRange", int'(remainder) < FRAC_DEN, remainder, FRAC_DEN - 1);
                if (monNote.n == prevNote + 1)
                    checkOutput("remIncreasing", int'(remainder) > prevRem, remainder, prevRem + 1);
                if (monNote.n == A4_NOTE) begin
                    carries = (longint'(remainder) * 64'd100_000_000) / longint'(FRAC_DEN);
                    checkOutput("accum440", (carries >= 225279) && (carries <= 225281),
                                carries, 225280);
                end
                prevNote = monNote.n;
                prevRem  = int'(remainder);
            end
        end
        if (sinePending) begin
            if (sineQ.size() == 0) begin
                checkOutput("sineQueueEmpty", 1'b0, 0, 1);
            end else begin
                monSine = sineQ.pop_front();
                checkOutput("sineValue", int'(value) == monSine.val, value, monSine.val);
                if (monSine.ph == 0 && prevPhase == 511) begin
                    stepDiff = int'(value) - prevValue;
                    if (stepDiff < 0) stepDiff = -stepDiff;
                    checkOutput("wrapStep", stepDiff <= 4, stepDiff, 4);
                end
                prevPhase = monSine.ph;
                prevValue = int'(value);
            end
        end
        if (directReq) begin
            if (directQ.size() == 0) begin
                checkOutput("directQueueEmpty", 1'b0, 0, 1);
            end else begin
                monDirect = directQ.pop_front();
                checkOutput("resetValue", int'(value) == monDirect, value, monDirect);
            end
        end
        if (finalReq) begin
            checkOutput("drainNote", noteQ.size() == 0, noteQ.size(), 0);
            checkOutput("drainSine", sineQ.size() == 0, sineQ.size(), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting note_tone_core bench");
        // Midscale must be visible while reset is held from time zero.
        expectDirect(256);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed reference points for the increment table.
        applyStimulus(0, 0, 1'b1, 1'b0, 0, 0, -1);
        applyStimulus(10, 0, 1'b1, 1'b0, 0, 225280, -1);
        applyStimulus(22, 0, 1'b1, 1'b0, 0, 450560, -1);

        // Quadrant boundaries of the sine table.
        applyStimulus(0, 0, 1'b0, 1'b1, -1, -1, 256);
        applyStimulus(0, 128, 1'b0, 1'b1, -1, -1, 511);
        applyStimulus(0, 256, 1'b0, 1'b1, -1, -1, 256);
        applyStimulus(0, 384, 1'b0, 1'b1, -1, -1, 1);

        // Ascending note sweep against the model (also checks monotonicity).
        for (int n = 1; n < 32; n++) begin
            applyStimulus(n, 0, 1'b1, 1'b0, -1, -1, -1);
        end

        // Asynchronous reset while the output sits at the peak.
        applyStimulus(0, 128, 1'b0, 1'b1, -1, -1, 511);
        applyStimulus(0, 128, 1'b0, 1'b0, -1, -1, -1);
        rst = 1'b1;
        expectDirect(256);
        @(posedge clk);
        #1;
        expectDirect(256);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expectDirect(511);
        @(posedge clk);
        #1;

        // Back-to-back phase sweep including the 511 -> 0 wrap.
        for (int p = 0; p < 516; p++) begin
            applyStimulus(0, p % 512, 1'b0, 1'b1, -1, -1, -1);
        end

        // Random notes and phases together.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(int'($urandom_range(31, 0)), int'($urandom_range(511, 0)),
                          1'b1, 1'b1, -1, -1, -1);
        end

        applyStimulus(0, 0, 1'b0, 1'b0, -1, -1, -1);
        applyStimulus(0, 0, 1'b0, 1'b0, -1, -1, -1);
        finalReq = 1'b1;
        @(negedge clk);
        #1;
        finalReq = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
